// File: rtl/scan_decoder_if.sv
// scan_decoder_if
//   Groups the scan-bus inputs and the decoded outputs of scan_decoder.
//   slave  : decoder side (samples anode/cathode/err_clr, drives results)
//   master : producer/observer side (drives scan pins, reads results)
//   anode[7:0]      active-low digit enables (bit0 ones, bit1 tens)
//   cathode[6:0]    active-low segments, bit0 = a .. bit6 = g
//   err_clr         synchronous clear of decode_err
//   value[6:0]      last complete decoded count 0..99
//   ones_digit/tens_digit  BCD digits of value
//   valid           a frame completed recently
//   frame_done      one-cycle pulse per completed frame
//   decode_err      sticky error flag
interface scan_decoder_if;
    logic [7:0] anode;
    logic [6:0] cathode;
    logic       err_clr;
    logic [6:0] value;
    logic [3:0] ones_digit;
    logic [3:0] tens_digit;
    logic       valid;
    logic       frame_done;
    logic       decode_err;

    modport slave (
        input  anode, cathode, err_clr,
        output value, ones_digit, tens_digit, valid, frame_done, decode_err
    );

    modport master (
        output anode, cathode, err_clr,
        input  value, ones_digit, tens_digit, valid, frame_done, decode_err
    );
endinterface

// File: rtl/scan_decoder.sv
// scan_decoder
//   Recovers a two-digit count (0..99) by watching the anode/cathode pins
//   of a multiplexed 7-segment display. Inputs are registered once, a
//   stability counter debounces each scan slot, and a legal stable slot on
//   anode bit 0/1 loads a pending digit. When both digits are pending the
//   frame FSM commits them to the outputs.
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      scan_decoder_if.slave (pins in, decoded results out)
module scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic            clk,
    input  logic            reset_n,
    scan_decoder_if.slave   bus
);

    localparam int TW = 25;
    localparam logic [7:0]    SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [7:0]    STB_AT  = 8'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic {COLLECT, COMMIT} state_t;

    // {ok, digit}; ok=0 for any pattern that is not a decimal digit
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h40:   seg_decode = 5'h10;
            7'h79:   seg_decode = 5'h11;
            7'h24:   seg_decode = 5'h12;
            7'h30:   seg_decode = 5'h13;
            7'h19:   seg_decode = 5'h14;
            7'h12:   seg_decode = 5'h15;
            7'h02:   seg_decode = 5'h16;
            7'h78:   seg_decode = 5'h17;
            7'h00:   seg_decode = 5'h18;
            7'h10:   seg_decode = 5'h19;
            default: seg_decode = 5'h00;
        endcase
    endfunction

    // input stage and debounce
    logic [7:0]    an_q, an_prev;
    logic [6:0]    ca_q, ca_prev;
    logic [7:0]    stab_cnt;

    // frame state
    state_t        state;
    logic [3:0]    pend_ones, pend_tens;
    logic          have_ones, have_tens;
    logic [TW-1:0] tmo_cnt;
    logic [6:0]    value_q;
    logic [3:0]    ones_q, tens_q;
    logic          valid_q, frame_done_q, err_q;

    // strobe decode
    logic          same;
    logic          stb;
    logic [7:0]    an_low;
    logic          multi_low;
    logic          hit_ones, hit_tens;
    logic [4:0]    seg_dec;
    logic          ld_ones, ld_tens, err_set;
    logic [6:0]    frame_val;
    logic [TW-1:0] tmo_nxt;

    always_comb begin
        same      = (an_q == an_prev) && (ca_q == ca_prev);
        // counter is about to become SETTLE on this edge: fires once per
        // stable interval because the counter then sits saturated
        stb       = same && (stab_cnt == STB_AT);
        an_low    = ~an_q;
        multi_low = |(an_low & (an_low - 8'd1));
        hit_ones  = stb && (an_low == 8'h01);
        hit_tens  = stb && (an_low == 8'h02);
        seg_dec   = seg_decode(ca_q);
        ld_ones   = hit_ones && seg_dec[4];
        ld_tens   = hit_tens && seg_dec[4];
        err_set   = (stb && multi_low) || ((hit_ones || hit_tens) && !seg_dec[4]);
        // tens*10 + ones = tens*8 + tens*2 + ones, max 99
        frame_val = {pend_tens, 3'b000} + {2'b00, pend_tens, 1'b0} + {3'b000, pend_ones};
        tmo_nxt   = (tmo_cnt == TMO_LIM) ? tmo_cnt : tmo_cnt + TW'(1);
    end

    // input registers and stability counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_q     <= 8'hFF;
            ca_q     <= 7'h7F;
            an_prev  <= 8'hFF;
            ca_prev  <= 7'h7F;
            stab_cnt <= 8'd0;
        end else begin
            an_q    <= bus.anode;
            ca_q    <= bus.cathode;
            an_prev <= an_q;
            ca_prev <= ca_q;
            if (!same)
                stab_cnt <= 8'd0;
            else if (stab_cnt != SETTLE)
                stab_cnt <= stab_cnt + 8'd1;
        end
    end

    // frame FSM with registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= COLLECT;
            pend_ones    <= 4'd0;
            pend_tens    <= 4'd0;
            have_ones    <= 1'b0;
            have_tens    <= 1'b0;
            tmo_cnt      <= '0;
            value_q      <= 7'd0;
            ones_q       <= 4'd0;
            tens_q       <= 4'd0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;

            // a new error wins over a coincident clear
            if (err_set)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;

            case (state)
                COLLECT: begin
                    if (have_ones && have_tens)
                        state <= COMMIT;
                    tmo_cnt <= tmo_nxt;
                    if (tmo_nxt == TMO_LIM)
                        valid_q <= 1'b0;
                end
                COMMIT: begin
                    ones_q       <= pend_ones;
                    tens_q       <= pend_tens;
                    value_q      <= frame_val;
                    frame_done_q <= 1'b1;
                    valid_q      <= 1'b1;
                    have_ones    <= 1'b0;
                    have_tens    <= 1'b0;
                    tmo_cnt      <= '0;
                    state        <= COLLECT;
                end
                default: state <= COLLECT;
            endcase

            // placed after the flag clear so a strobe landing in COMMIT
            // starts the next frame instead of being lost
            if (ld_ones) begin
                pend_ones <= seg_dec[3:0];
                have_ones <= 1'b1;
            end
            if (ld_tens) begin
                pend_tens <= seg_dec[3:0];
                have_tens <= 1'b1;
            end
        end
    end

    assign bus.value      = value_q;
    assign bus.ones_digit = ones_q;
    assign bus.tens_digit = tens_q;
    assign bus.valid      = valid_q;
    assign bus.frame_done = frame_done_q;
    assign bus.decode_err = err_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder
//   Table of scan-pin patterns with expected decode_err after each, and
//   expected frame values queued when the completing pattern is driven; a
//   negedge monitor pops and checks each frame_done. Hand sequences cover
//   unstable toggling, timeout, error clear coincidence and mid-frame reset.
module tb_scan_decoder;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    scan_decoder_if bus();

    scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] an;
        logic [6:0] ca;
        int         hold;
        bit         clr;
        bit         push;
        int         exp_val;
        bit         exp_err;
    } vec_t;

    vec_t tbl[15];
    int   total = 0;
    int   bad   = 0;
    int   q[$];
    int   cyc = 0;
    int   fd_cyc = 0;
    int   fd_count = 0;
    bit   prev_fd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic apply(input logic [7:0] an, input logic [6:0] ca, input int n);
        bus.anode   = an;
        bus.cathode = ca;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // frame monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n && bus.frame_done) begin
            fd_count++;
            fd_cyc = cyc;
            chk("fd_not_back_to_back", int'(prev_fd), 0);
            if (q.size() == 0) begin
                chk("unexpected_frame_value", int'(bus.value), -1);
            end else begin
                int e;
                e = q.pop_front();
                chk("frame_value", int'(bus.value), e);
                chk("frame_tens", int'(bus.tens_digit), e / 10);
                chk("frame_ones", int'(bus.ones_digit), e % 10);
                chk("frame_valid", int'(bus.valid), 1);
            end
        end
        prev_fd = bus.frame_done;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int base;
        //            an     ca    hold clr push val err
        tbl[0]  = '{8'hFE, 7'h12, 8, 0, 0,  0, 0};  // ones=5
        tbl[1]  = '{8'hFD, 7'h19, 8, 0, 1, 45, 0};  // tens=4 -> 45
        tbl[2]  = '{8'hFF, 7'h7F, 8, 0, 0,  0, 0};  // blank
        tbl[3]  = '{8'hFE, 7'h7F, 8, 0, 0,  0, 1};  // bad segments
        tbl[4]  = '{8'hFF, 7'h7F, 4, 1, 0,  0, 0};  // clear
        tbl[5]  = '{8'hFC, 7'h40, 8, 0, 0,  0, 1};  // two anodes low
        tbl[6]  = '{8'hFF, 7'h7F, 4, 1, 0,  0, 0};  // clear
        tbl[7]  = '{8'hFB, 7'h00, 8, 0, 0,  0, 0};  // digit 2: ignored
        tbl[8]  = '{8'hFD, 7'h24, 8, 0, 0,  0, 0};  // tens=2
        tbl[9]  = '{8'hFE, 7'h79, 8, 0, 1, 21, 0};  // ones=1 -> 21
        tbl[10] = '{8'hFE, 7'h78, 8, 0, 0,  0, 0};  // ones=7
        tbl[11] = '{8'hFE, 7'h02, 8, 0, 0,  0, 0};  // ones=6 overwrites
        tbl[12] = '{8'hFD, 7'h30, 8, 0, 1, 36, 0};  // tens=3 -> 36
        tbl[13] = '{8'hFE, 7'h10, 8, 0, 0,  0, 0};  // ones=9
        tbl[14] = '{8'hFD, 7'h10, 8, 0, 1, 99, 0};  // tens=9 -> 99

        reset_n     = 1'b0;
        bus.anode   = 8'hFF;
        bus.cathode = 7'h7F;
        bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", int'(bus.value), 0);
        chk("rst_ones", int'(bus.ones_digit), 0);
        chk("rst_tens", int'(bus.tens_digit), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_frame_done", int'(bus.frame_done), 0);
        chk("rst_err", int'(bus.decode_err), 0);
        reset_n = 1'b1;

        // never stable long enough to strobe
        for (int i = 0; i < 8; i++)
            apply((i % 2) ? 8'hFD : 8'hFE, 7'h40, 3);
        chk("toggle_no_frame", fd_count, 0);
        chk("toggle_valid", int'(bus.valid), 0);
        chk("toggle_err", int'(bus.decode_err), 0);
        apply(8'hFF, 7'h7F, 8);

        for (int i = 0; i < 15; i++) begin
            bus.err_clr = tbl[i].clr;
            if (tbl[i].push) q.push_back(tbl[i].exp_val);
            apply(tbl[i].an, tbl[i].ca, tbl[i].hold);
            bus.err_clr = 1'b0;
            chk($sformatf("tbl%0d_err", i), int'(bus.decode_err), int'(tbl[i].exp_err));
        end
        repeat (2) @(negedge clk);
        chk("tbl_frames", fd_count, 4);

        // timeout: valid drops 64 cycles after the 99 frame, value holds
        bus.anode   = 8'hFF;
        bus.cathode = 7'h7F;
        while (cyc < fd_cyc + 63) @(negedge clk);
        chk("tmo_valid_before", int'(bus.valid), 1);
        while (cyc < fd_cyc + 64) @(negedge clk);
        chk("tmo_valid_after", int'(bus.valid), 0);
        chk("tmo_value_hold", int'(bus.value), 99);
        chk("tmo_tens_hold", int'(bus.tens_digit), 9);
        chk("tmo_ones_hold", int'(bus.ones_digit), 9);
        @(posedge clk);
        #1;

        // new error coinciding with err_clr keeps the flag set
        apply(8'hFE, 7'h7F, 5);
        chk("coin_err_pre", int'(bus.decode_err), 0);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("coin_err_set_wins", int'(bus.decode_err), 1);
        @(posedge clk);
        #1;
        chk("coin_err_cleared", int'(bus.decode_err), 0);
        bus.err_clr = 1'b0;

        // reset mid-frame discards pending ones digit
        apply(8'hFE, 7'h78, 8);
        bus.anode   = 8'hFF;
        bus.cathode = 7'h7F;
        reset_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_value", int'(bus.value), 0);
        chk("midrst_valid", int'(bus.valid), 0);
        reset_n = 1'b1;
        base = fd_count;
        apply(8'hFD, 7'h30, 8);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_no_frame", fd_count, base);
        chk("midrst_value_zero", int'(bus.value), 0);
        q.push_back(32);
        apply(8'hFE, 7'h24, 8);
        repeat (2) @(negedge clk);
        chk("midrst_frame", fd_count, base + 1);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: consecutive stable cycles required before a scan slot is sampled (legal range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: cycles without a completed frame before valid drops (legal range 16..2^24).
REQ-003 Port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port anode  input  8  active-low digit enables, as produced by the display scan logic; bit 0 = ones digit, bit 1 = tens digit.
REQ-006 Port cathode  input  7  active-low segments, bit 0 = a through bit 6 = g.
REQ-007 Port err_clr  input  1  synchronous clear of decode_err.
REQ-008 Port value  output  7  last complete decoded count, 0..99.
REQ-009 Port ones_digit  output  4  BCD ones digit of value.
REQ-010 Port tens_digit  output  4  BCD tens digit of value.
REQ-011 Port valid  output  1  value reflects a frame completed within TIMEOUT_CYCLES.
REQ-012 Port frame_done  output  1  one-cycle pulse per completed frame.
REQ-013 Port decode_err  output  1  sticky error flag.

Function
REQ-014 {anode, cathode} SHALL be registered once (input stage) before any comparison; no combinational path from inputs to outputs.
REQ-015 Stability counter SHALL clear to 0 when the registered sample differs from the previous registered sample, else increment, saturating at SETTLE_CYCLES.
REQ-016 A sample strobe SHALL fire exactly once per stable interval, on the edge where the counter becomes SETTLE_CYCLES; a pattern applied and held is strobed at the (SETTLE_CYCLES+2)th rising edge after it appears on the pins.
REQ-017 At strobe, anode all-ones (blank) or a single low bit in positions 2..7 SHALL be ignored with no state change.
REQ-018 At strobe, more than one low anode bit SHALL set decode_err and discard the sample.
REQ-019 Segment decode (cathode hex, active-low): 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9; any other pattern on anode bit 0 or 1 SHALL set decode_err and discard the sample.
REQ-020 Legal strobe on anode bit 0 SHALL load pend_ones and set have_ones; on bit 1 load pend_tens and set have_tens; a repeat before frame completion overwrites the pending digit.
REQ-021 Frame FSM states: COLLECT (one or neither digit pending) and COMMIT (both pending); COLLECT->COMMIT when both flags set; COMMIT->COLLECT unconditionally next cycle.
REQ-022 In COMMIT: ones_digit, tens_digit load pending digits; value loads tens*10+ones (7-bit, no overflow possible); frame_done=1 for that cycle only; valid<=1; both flags cleared; timeout counter cleared.
REQ-023 A strobe arriving in the COMMIT cycle SHALL be applied after flag clearing (counts toward the next frame, not lost).
REQ-024 Timeout counter SHALL increment every cycle outside COMMIT, saturating; on reaching TIMEOUT_CYCLES valid SHALL clear; value and digits hold their last contents.
REQ-025 decode_err SHALL remain set until err_clr=1 at a clock edge; if err_clr and a new error coincide, decode_err SHALL remain 1.
REQ-026 frame_done SHALL never assert on two consecutive cycles.

Reset
REQ-027 reset_n=0 SHALL immediately force value=0, ones_digit=0, tens_digit=0, valid=0, frame_done=0, decode_err=0, FSM=COLLECT, pending flags, stability and timeout counters cleared, input registers to all-ones (blank).
REQ-028 Reset asserted mid-frame SHALL discard pending digits; first frame after release requires fresh strobes of both digits.

Verification (SETTLE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-029 Hold anode=FE cathode=12, 8 cycles, then anode=FD cathode=19, 8 cycles -> one frame_done pulse, value=45, tens=4, ones=5, valid=1, decode_err=0.
REQ-030 anode=FE cathode=40 toggled to FD each 3 cycles (never stable 4) -> no strobe, frame_done stays 0, valid stays 0.
REQ-031 anode=FE cathode=7F held 8 cycles -> decode_err=1, no pending digit; err_clr pulse -> decode_err=0.
REQ-032 anode=FC held 8 cycles -> decode_err=1; anode=FB cathode=00 held 8 cycles -> no effect on value or flags.
REQ-033 Complete frame value=99 (cathode 10 on both), then blank anodes for 70 cycles -> valid falls to 0 at cycle 64 after frame_done, value stays 99.
REQ-034 Strobe ones=7, assert reset_n=0 for 2 cycles, release, strobe tens=3 only -> no frame_done, value=0; then strobe ones=2 -> value=32.
